// File: rtl/spi_reg_master.sv
// rtl/spi_reg_master.sv - SPI mode-0 initiator shifting a left-aligned word out MSB-first
//
// Purpose:
//   Drives csb/sclk/mosi of a register/vector SPI receiver. A frame is
//   SETUP, then len x (HIGH, LOW), then GAP; every phase lasts CLK_DIV
//   clocks. The receiver samples mosi on each rising sclk; mosi only moves
//   on the clock that drops sclk, so it is stable around every rising edge.
//   All outputs come straight from flops.
//
// Optional feature macro: SPI_REG_MASTER_READBACK_EN
//   Adds i_miso / o_rdata; i_miso is captured with every rising sclk and the
//   received bits are presented right-aligned together with o_done.
//
// Ports:
//   i_clk      system clock
//   i_reset_n  synchronous active-low reset
//   i_start    frame request, only looked at while idle
//   i_data     left-aligned payload, bit MAX_BITS-1 goes first
//   i_len      bits to send, 1..MAX_BITS (other values are ignored)
//   i_miso     serial data in (readback build only)
//   o_rdata    received bits, right-aligned (readback build only)
//   o_busy     frame in progress
//   o_done     one-cycle pulse at frame end
//   o_csb      chip select, active low
//   o_sclk     serial clock, idles low
//   o_mosi     serial data out
module spi_reg_master #(
   parameter int MAX_BITS = 80,
   parameter int CNT_W    = 7,
   parameter int CLK_DIV  = 2
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_start,
   input  logic [MAX_BITS-1:0] i_data,
   input  logic [CNT_W-1:0]    i_len,
`ifdef SPI_REG_MASTER_READBACK_EN
   input  logic                i_miso,
   output logic [MAX_BITS-1:0] o_rdata,
`endif
   output logic                o_busy,
   output logic                o_done,
   output logic                o_csb,
   output logic                o_sclk,
   output logic                o_mosi
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HIGH,
      ST_LOW,
      ST_GAP
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [DIV_W-1:0]    div_cnt;
   logic [DIV_W-1:0]    div_nx;
   logic [CNT_W-1:0]    bit_cnt;
   logic [CNT_W-1:0]    bit_nx;
   logic [MAX_BITS-1:0] shreg;
   logic [MAX_BITS-1:0] shreg_nx;
   logic                csb_nx;
   logic                sclk_nx;
   logic                mosi_nx;
   logic                busy_nx;
   logic                done_nx;
   logic                div_last;
   logic                len_ok;
   logic                accept;
   logic                rise;

   assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign len_ok   = (i_len != '0) && (i_len <= CNT_W'(MAX_BITS));
   assign accept   = (state == ST_IDLE) && i_start && len_ok;

   // Next-state and next-output logic. Outputs are computed one step ahead
   // so that the flops below present them aligned with the state.
   always_comb begin
      state_nx = state;
      div_nx   = div_cnt;
      bit_nx   = bit_cnt;
      shreg_nx = shreg;
      csb_nx   = o_csb;
      sclk_nx  = o_sclk;
      mosi_nx  = o_mosi;
      busy_nx  = o_busy;
      done_nx  = 1'b0;
      rise     = 1'b0;

      if (state != ST_IDLE) begin
         div_nx = div_last ? '0 : div_cnt + DIV_W'(1);
      end

      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nx = ST_SETUP;
               div_nx   = '0;
               bit_nx   = i_len;
               shreg_nx = i_data;
               csb_nx   = 1'b0;
               sclk_nx  = 1'b0;
               mosi_nx  = i_data[MAX_BITS-1];
               busy_nx  = 1'b1;
            end
         end
         ST_SETUP: begin
            if (div_last) begin
               state_nx = ST_HIGH;
               sclk_nx  = 1'b1;
               rise     = 1'b1;
            end
         end
         ST_HIGH: begin
            // Falling sclk: advance to the next bit, except after the last
            // one where mosi is held through the trailing LOW.
            if (div_last) begin
               state_nx = ST_LOW;
               sclk_nx  = 1'b0;
               bit_nx   = bit_cnt - CNT_W'(1);
               if (bit_cnt != CNT_W'(1)) begin
                  shreg_nx = shreg << 1;
                  mosi_nx  = shreg[MAX_BITS-2];
               end
            end
         end
         ST_LOW: begin
            if (div_last) begin
               if (bit_cnt == '0) begin
                  state_nx = ST_GAP;
                  csb_nx   = 1'b1;
                  mosi_nx  = 1'b0;
               end else begin
                  state_nx = ST_HIGH;
                  sclk_nx  = 1'b1;
                  rise     = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (div_last) begin
               state_nx = ST_IDLE;
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
            end
         end
         default: begin
            state_nx = ST_IDLE;
            csb_nx   = 1'b1;
            sclk_nx  = 1'b0;
            mosi_nx  = 1'b0;
            busy_nx  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state   <= ST_IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         o_csb   <= 1'b1;
         o_sclk  <= 1'b0;
         o_mosi  <= 1'b0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         state   <= state_nx;
         div_cnt <= div_nx;
         bit_cnt <= bit_nx;
         shreg   <= shreg_nx;
         o_csb   <= csb_nx;
         o_sclk  <= sclk_nx;
         o_mosi  <= mosi_nx;
         o_busy  <= busy_nx;
         o_done  <= done_nx;
      end
   end

`ifdef SPI_REG_MASTER_READBACK_EN
   // Cleared on accept so that after len rising edges the upper bits are 0.
   logic [MAX_BITS-1:0] rx_sh;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         rx_sh   <= '0;
         o_rdata <= '0;
      end else begin
         if (accept) begin
            rx_sh <= '0;
         end else if (rise) begin
            rx_sh <= {rx_sh[MAX_BITS-2:0], i_miso};
         end
         if (done_nx) begin
            o_rdata <= rx_sh;
         end
      end
   end
`endif

endmodule
